// File: rtl/apb_pmu_seq.sv
// ---------------------------------------------------------------------------
// apb_pmu_seq
//
// APB-programmable power-domain sequencer. Software writes a domain MASK,
// a SETTLE time and a direction, then writes GO. The sequencer walks the
// selected domains one at a time through the clock-gate / reset /
// sleep-request / acknowledge handshake and pulses irq_o when finished.
//
// Optional feature macro: APB_PMU_SEQ_TIMEOUT_EN
//   defined   : WAIT_ACK is bounded by the TIMEOUT register (0 = no limit);
//               expiry enters ERR, sets the sticky err flag and pulses irq_o.
//   undefined : WAIT_ACK waits forever, TIMEOUT reads 0, err is always 0.
//
// Parameters
//   APB_ADDR_WIDTH : APB address width (only PADDR[4:0] decoded)
//   NUM_DOM        : number of power domains (1..16)
//   CNT_WIDTH      : width of the SETTLE / TIMEOUT counters
//
// Ports
//   HCLK, HRESETn          : clock, asynchronous active-low reset
//   PADDR/PWDATA/PWRITE/
//   PSEL/PENABLE           : APB request
//   PRDATA/PREADY/PSLVERR  : APB response (PREADY tied high)
//   sleep_req_o            : per-domain power-off request
//   sleep_ack_i            : per-domain switch acknowledge (asynchronous)
//   dom_rstn_o             : per-domain active-low reset
//   clk_en_o               : per-domain clock enable
//   irq_o                  : one-cycle completion / error pulse
//
// Register map (byte offsets)
//   0x00 SIGNATURE RO 0x00DA41DF   0x04 SCRATCH RW
//   0x08 CTRL  bit0 GO (W1, reads 0), bit1 DIR (0 down, 1 up)
//   0x0C MASK  0x10 SETTLE  0x14 STATUS  0x18 TIMEOUT
// ---------------------------------------------------------------------------
module apb_pmu_seq #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_DOM        = 5,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [NUM_DOM-1:0]        sleep_req_o,
    input  logic [NUM_DOM-1:0]        sleep_ack_i,
    output logic [NUM_DOM-1:0]        dom_rstn_o,
    output logic [NUM_DOM-1:0]        clk_en_o,
    output logic                      irq_o
);

    localparam logic [31:0] SIGNATURE_VAL = 32'h00DA41DF;

    localparam logic [4:0] ADDR_SIG     = 5'h00;
    localparam logic [4:0] ADDR_SCRATCH = 5'h04;
    localparam logic [4:0] ADDR_CTRL    = 5'h08;
    localparam logic [4:0] ADDR_MASK    = 5'h0C;
    localparam logic [4:0] ADDR_SETTLE  = 5'h10;
    localparam logic [4:0] ADDR_STATUS  = 5'h14;
    localparam logic [4:0] ADDR_TIMEOUT = 5'h18;

    typedef enum logic [3:0] {
        IDLE,
        SCAN,
        CLK_OFF,
        RST_ON,
        REQ,
        WAIT_ACK,
        SETTLE,
        RST_OFF,
        CLK_ON,
        DONE
`ifdef APB_PMU_SEQ_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t               state;
    logic [3:0]           cur_idx;
    logic [CNT_WIDTH-1:0] cnt;
    logic [NUM_DOM-1:0]   dom_on;

    logic [31:0]          scratch;
    logic                 dir;
    logic [NUM_DOM-1:0]   mask;
    logic [CNT_WIDTH-1:0] settle_val;
    logic                 err;
`ifdef APB_PMU_SEQ_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] timeout_val;
    logic                 timeout_hit;
`endif

    logic [NUM_DOM-1:0]   ack_meta;
    logic [NUM_DOM-1:0]   ack_sync;

    logic [4:0]           addr;
    logic                 wr_acc;
    logic                 cfg_addr;
    logic                 reject;
    logic                 go_accept;
    logic                 busy;

    logic [NUM_DOM-1:0]   pending;
    logic [NUM_DOM-1:0]   sel;
    logic [3:0]           next_idx;
    logic                 found;
    logic                 ack_hit;
    logic                 settle_done;
    logic [31:0]          status;

    logic                 unused_bits;

    assign unused_bits = ^{PADDR, PWDATA};

    assign addr   = PADDR[4:0];
    assign wr_acc = PSEL && PENABLE && PWRITE;
    assign PREADY = 1'b1;

    // DONE and ERR already report not-busy so software sees completion in the
    // same cycle as the interrupt pulse.
`ifdef APB_PMU_SEQ_TIMEOUT_EN
    assign busy = (state != IDLE) && (state != DONE) && (state != ERR);
`else
    assign busy = (state != IDLE) && (state != DONE);
`endif

    // Write rejection: configuration is frozen while a walk is running, and a
    // new walk may not start until software has acknowledged a previous error.
    always_comb begin
        cfg_addr = (addr == ADDR_CTRL) || (addr == ADDR_MASK) ||
                   (addr == ADDR_SETTLE) || (addr == ADDR_TIMEOUT);
        reject   = wr_acc && ((busy && cfg_addr) ||
                              ((addr == ADDR_CTRL) && PWDATA[0] && err));
    end

    assign PSLVERR   = reject;
    assign go_accept = wr_acc && !reject && (addr == ADDR_CTRL) && PWDATA[0];

    // Two-flop synchroniser for the asynchronous switch acknowledges.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ack_meta <= '0;
            ack_sync <= '0;
        end else begin
            ack_meta <= sleep_ack_i;
            ack_sync <= ack_meta;
        end
    end

    // Software-visible configuration registers. MASK and DIR cannot change
    // while busy, so the FSM uses them directly as the values latched at GO.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            scratch     <= '0;
            dir         <= 1'b0;
            mask        <= '0;
            settle_val  <= '0;
`ifdef APB_PMU_SEQ_TIMEOUT_EN
            timeout_val <= '0;
`endif
        end else if (wr_acc && !reject) begin
            case (addr)
                ADDR_SCRATCH: scratch    <= PWDATA;
                ADDR_CTRL:    dir        <= PWDATA[1];
                ADDR_MASK:    mask       <= PWDATA[NUM_DOM-1:0];
                ADDR_SETTLE:  settle_val <= PWDATA[CNT_WIDTH-1:0];
`ifdef APB_PMU_SEQ_TIMEOUT_EN
                ADDR_TIMEOUT: timeout_val <= PWDATA[CNT_WIDTH-1:0];
`endif
                default: ;
            endcase
        end
    end

    // A domain is pending when it is selected and its power state differs
    // from the target level (DIR = 1 means "should be on").
    assign pending = mask & (dom_on ^ {NUM_DOM{dir}});

    // Power-down walks lowest index first, power-up highest index first, so
    // an up-walk undoes a down-walk in reverse order.
    always_comb begin
        found    = |pending;
        next_idx = '0;
        if (dir) begin
            for (int i = 0; i < NUM_DOM; i++) begin
                if (pending[i]) next_idx = 4'(i);
            end
        end else begin
            for (int i = NUM_DOM - 1; i >= 0; i--) begin
                if (pending[i]) next_idx = 4'(i);
            end
        end
    end

    assign sel = NUM_DOM'(1) << cur_idx;

    // Down waits for ack high, up waits for ack low.
    assign ack_hit = dir ? ((ack_sync & sel) == '0) : ((ack_sync & sel) != '0);

    // A SETTLE value of 0 still spends one cycle in the state.
    assign settle_done = (settle_val == '0) || (cnt == settle_val - 1'b1);

`ifdef APB_PMU_SEQ_TIMEOUT_EN
    assign timeout_hit = (timeout_val != '0) && (cnt == timeout_val - 1'b1);
`endif

    // Sequencer FSM with registered domain controls. Each control bit is only
    // touched for the selected domain; everything else holds its value.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= IDLE;
            cur_idx     <= '0;
            cnt         <= '0;
            dom_on      <= '1;
            sleep_req_o <= '0;
            dom_rstn_o  <= '1;
            clk_en_o    <= '1;
            irq_o       <= 1'b0;
`ifdef APB_PMU_SEQ_TIMEOUT_EN
            err         <= 1'b0;
`endif
        end else begin
            irq_o <= 1'b0;
`ifdef APB_PMU_SEQ_TIMEOUT_EN
            if (wr_acc && (addr == ADDR_STATUS) && PWDATA[1]) err <= 1'b0;
`endif
            case (state)
                SCAN: begin
                    if (found) begin
                        cur_idx <= next_idx;
                        state   <= dir ? REQ : CLK_OFF;
                    end else begin
                        irq_o <= 1'b1;
                        state <= DONE;
                    end
                end
                CLK_OFF: begin
                    clk_en_o <= clk_en_o & ~sel;
                    state    <= RST_ON;
                end
                RST_ON: begin
                    dom_rstn_o <= dom_rstn_o & ~sel;
                    state      <= REQ;
                end
                REQ: begin
                    sleep_req_o <= dir ? (sleep_req_o & ~sel) : (sleep_req_o | sel);
                    cnt         <= '0;
                    state       <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ack_hit) begin
                        cnt   <= '0;
                        state <= SETTLE;
                    end
`ifdef APB_PMU_SEQ_TIMEOUT_EN
                    else if (timeout_hit) begin
                        err   <= 1'b1;
                        irq_o <= 1'b1;
                        state <= ERR;
                    end
`endif
                    else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_done) begin
                        cnt <= '0;
                        if (dir) begin
                            state <= RST_OFF;
                        end else begin
                            dom_on <= dom_on & ~sel;
                            state  <= SCAN;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RST_OFF: begin
                    dom_rstn_o <= dom_rstn_o | sel;
                    state      <= CLK_ON;
                end
                CLK_ON: begin
                    clk_en_o <= clk_en_o | sel;
                    dom_on   <= dom_on | sel;
                    state    <= SCAN;
                end
                // IDLE, DONE and ERR all wait for the next accepted GO.
                default: begin
                    state <= go_accept ? SCAN : IDLE;
                end
            endcase
        end
    end

`ifndef APB_PMU_SEQ_TIMEOUT_EN
    assign err = 1'b0;
`endif

    // STATUS layout: busy, err, current domain index, per-domain power state.
    always_comb begin
        status                 = '0;
        status[0]              = busy;
        status[1]              = err;
        status[11:8]           = cur_idx;
        status[16 +: NUM_DOM]  = dom_on;
    end

    // Read mux, combinational from the address alone.
    always_comb begin
        PRDATA = '0;
        case (addr)
            ADDR_SIG:     PRDATA = SIGNATURE_VAL;
            ADDR_SCRATCH: PRDATA = scratch;
            ADDR_CTRL:    PRDATA = {30'b0, dir, 1'b0};
            ADDR_MASK:    PRDATA = 32'(mask);
            ADDR_SETTLE:  PRDATA = 32'(settle_val);
            ADDR_STATUS:  PRDATA = status;
`ifdef APB_PMU_SEQ_TIMEOUT_EN
            ADDR_TIMEOUT: PRDATA = 32'(timeout_val);
`endif
            default:      PRDATA = '0;
        endcase
    end

endmodule
